mult_div_unit: RTL

//  Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS datapath.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/mdu_iter_core.sv | 68 ++++++
 rtl/mult_div_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiply/divide opcodes, MDU width and FSM states.
`timescale 1ns/1ps
package mips_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE   = 2'd0,
    MDU_RUN    = 2'd1,
    MDU_FINISH = 2'd2
  } mdu_state_t;

  // MULT/MULTU/DIV/DIVU all have op[2]==0 and need the iterative core.
  function automatic logic mdu_is_iter(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iteration datapath for the MDU: one shift-add (multiply) or restoring
// subtract-shift (divide) step per cycle on unsigned magnitudes.
// After WIDTH steps: multiply -> {hi_o, lo_o} = product; divide -> hi_o = remainder, lo_o = quotient.
`timescale 1ns/1ps
module mdu_iter_core
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // acc carries one extra bit so the multiply partial sum never overflows
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic             div_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   add_sel;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Next value of the shift register pair for a single step
  always_comb begin
    sum     = acc_q + {1'b0, b_q};
    add_sel = lo_q[0] ? sum : acc_q;
    shifted = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, b_q};
    if (div_q) begin
      acc_d = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
      lo_d  = {lo_q[WIDTH-2:0], ~diff[WIDTH+1]};
    end else begin
      acc_d = {1'b0, add_sel[WIDTH:1]};
      lo_d  = {add_sel[0], lo_q[WIDTH-1:1]};
    end
  end

  // Operand load on accept, then one step per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc_q <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
      div_q <= div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
    end
  end

  assign hi_o = acc_q[WIDTH-1:0];
  assign lo_o = lo_q;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit owning the HI/LO pair. Multi-cycle MULT/MULTU/DIV/DIVU,
// single-cycle MTHI/MTLO. Optional macro MDU_DIVZERO_FLAG_EN adds the div_zero output.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO complete here
// RUN    | WIDTH iteration steps in the core
// FINISH | sign fix-up, HI/LO write, done pulse
`timescale 1ns/1ps
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mdu_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic             div_q, neg_a_q, neg_b_q, bzero_q;

  logic             accept, core_load, core_step, finish, move_go;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] hi_fix, lo_fix;

  // Signed ops (MULT, DIV) have op[0]==0; operands go to the core as magnitudes
  assign a_neg = ~op[0] & op_a[WIDTH-1];
  assign b_neg = ~op[0] & op_b[WIDTH-1];
  assign a_abs = a_neg ? -op_a : op_a;
  assign b_abs = b_neg ? -op_b : op_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE:   if (start && mdu_is_iter(op)) state_d = MDU_RUN;
      MDU_RUN:    if (cnt_q == CNT_LAST) state_d = MDU_FINISH;
      MDU_FINISH: state_d = MDU_IDLE;
      default:    state_d = MDU_IDLE;
    endcase
  end

  // FSM outputs and control strobes
  always_comb begin
    busy      = (state_q != MDU_IDLE);
    accept    = (state_q == MDU_IDLE) && start;
    core_load = accept && mdu_is_iter(op);
    move_go   = accept && ((op == MDU_MTHI) || (op == MDU_MTLO));
    core_step = (state_q == MDU_RUN);
    finish    = (state_q == MDU_FINISH);
  end

  // Sign correction of the magnitude result; divide by zero keeps quotient all ones
  always_comb begin
    prod     = {core_hi, core_lo};
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    if (div_q) begin
      hi_fix = neg_a_q ? -core_hi : core_hi;
      if (bzero_q)                lo_fix = '1;
      else if (neg_a_q ^ neg_b_q) lo_fix = -core_lo;
      else                        lo_fix = core_lo;
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  // Operation context, step counter, HI/LO and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      done_q <= finish | move_go;
      if (core_load) begin
        cnt_q   <= '0;
        div_q   <= op[1];
        neg_a_q <= a_neg;
        neg_b_q <= b_neg;
        bzero_q <= op[1] && (op_b == '0);
      end
      if (core_step) cnt_q <= cnt_q + 1'b1;
      if (move_go) begin
        if (op == MDU_MTHI) hi_q <= op_a;
        else                lo_q <= op_a;
      end
      if (finish) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
    end
  end

`ifdef MDU_DIVZERO_FLAG_EN
  logic divz_q;

  // Sticky divide-by-zero flag, cleared by the next accepted op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         divz_q <= 1'b0;
    else if (finish && div_q && bzero_q) divz_q <= 1'b1;
    else if (core_load || move_go)      divz_q <= 1'b0;
  end

  assign div_zero = divz_q;
`endif

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (core_load),
    .step_i (core_step),
    .div_i  (op[1]),
    .a_i    (a_abs),
    .b_i    (b_abs),
    .hi_o   (core_hi),
    .lo_o   (core_lo)
  );

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
